banked_ram: RTL
===============

Name: banked_ram

Overview:
Parametrised successor to the flat work/high RAM block. Provides CGB-style banked WRAM: a fixed bank 0 plus a switchable bank selected by the SVBK register at FF70, with an echo mirror and separate HRAM.
Adds an optional post-reset clear sequencer that zeroes both arrays and reports busy. Sits on the MMU peripheral buses alongside the PPU and cartridge.

Parameters:
- NUM_BANKS, 8, number of 4 KiB WRAM banks; power of two, at least 2.
- BANK_SIZE, 4096, bytes per WRAM bank; power of two.
- HRAM_LEN, 127, HRAM bytes, mapped FF80..FF80+HRAM_LEN-1.
- BANK_BITS, $clog2(NUM_BANKS), derived localparam; not overridable.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bus  Bus_if.Peripheral_side  —  WRAM and echo accesses (addr, wdata, rdata, read_en, write_en)
- hram_bus  Bus_if.Peripheral_side  —  HRAM accesses
- io_bus  Bus_if.Peripheral_side  —  I/O register accesses; only FF70 (SVBK) is decoded
- cgb_mode  in  1  1 means CGB banking enabled; 0 means DMG behaviour
- busy  out  1  clear sequence in progress

Behaviour:
- Reset values:
  - svbk = 0.
  - busy = 1 with RAM_CLEAR_ON_RESET_EN defined, else 0.
  - rdata on all buses = FF while reset is high.
- Bank decode:
  - eff_bank = 1 when cgb_mode = 0 or svbk = 0; otherwise eff_bank = svbk.
  - C000-CFFF maps to bank 0; D000-DFFF maps to eff_bank.
  - E000-FDFF mirrors C000-DDFF: same decode with addr - 2000.
- Array index = {bank[BANK_BITS-1:0], addr[$clog2(BANK_SIZE)-1:0]}. Array depth = NUM_BANKS*BANK_SIZE.
- Reads are combinational:
  - rdata = FF unless read_en is high, the address is selected and busy = 0.
  - HRAM index = addr - FF80, truncated to $clog2(HRAM_LEN+1) bits.
- Writes are committed on posedge clk when write_en is high, the address is selected and busy = 0. Writes while busy are dropped silently.
- SVBK register at FF70 on io_bus:
  - Write with cgb_mode = 1 stores wdata[BANK_BITS-1:0].
  - Read with cgb_mode = 1 returns upper bits all 1 with svbk in the low BANK_BITS.
  - With cgb_mode = 0: reads return FF and writes are ignored.
  - SVBK access is unaffected by busy.
- Simultaneous events, same cycle:
  - SVBK write plus D000 access: the access uses the old bank. The new bank applies from the next cycle.
  - WRAM and HRAM writes are independent and both commit.
  - SVBK write value 0 selects bank 1 for decode; a readback returns the stored 0.
- Clear FSM (macro on only). States: CLEAR, IDLE.
  - Reset forces CLEAR with cnt = 0.
  - In CLEAR, each cycle writes 00 to WRAM[cnt], and to HRAM[cnt] when cnt < HRAM_LEN, then increments cnt.
  - When cnt = NUM_BANKS*BANK_SIZE-1, write that last location and go to IDLE. busy deasserts on that edge.
  - Clear duration = NUM_BANKS*BANK_SIZE cycles (32768 at defaults).
  - Reset asserted mid-clear restarts the sequence at cnt = 0.
  - IDLE is terminal until the next reset.

Optional Feature:
- Macro: RAM_CLEAR_ON_RESET_EN.
- Defined: clear FSM present; busy and access gating behave as described above.
- Undefined: no FSM and no counter; busy is tied 0; array contents after reset are unspecified; accesses are legal from the first cycle after reset deasserts.

Decomposition:
- mmu_addresses_pkg additions:
  - SVBK_addr = 16'hFF70.
  - WRAM_bank0_start/end = C000/CFFF.
  - WRAM_bankN_start/end = D000/DFFF.
  - Echo constants: reuse the existing ones.
- Sub-module ram_clear_seq: FSM plus counter, parametrised by DEPTH. Outputs busy, clr_we and clr_addr. Instantiated only under the macro.

Test Plan:
- Reset, macro on: hold reset 2 cycles, release, count cycles → busy stays high for exactly 32768 cycles, then 0. Reading C000 and D123 returns 00. Writing C000 = 5A while busy is dropped, so a later read returns 00.
- cgb_mode = 1:
  - SVBK = 3, write D010 = 33.
  - SVBK = 5, write D010 = 55.
  - Read D010 → 55. Set SVBK = 3 again, read D010 → 33. Read FF70 → F8 | 3 = FB.
- SVBK = 0: write D200 = 11, then set SVBK = 1 and read D200 → 11. Readback of FF70 after writing 0 → F8.
- cgb_mode = 0: write FF70 = 04, read FF70 → FF. Write D000 = AB, set cgb_mode = 1 with SVBK = 2, read D000 → not AB (bank 2). Restore SVBK = 1, read D000 → AB.
- Echo and same-cycle events:
  - Write E000 = 77, read C000 → 77.
  - Write FDFF = 99, read DDFF → 99.
  - In the same cycle, io_bus writes SVBK = 6 and bus writes D001 = 42. The write lands in the old bank 1, so reading D001 under SVBK = 1 → 42.
- HRAM: write FF80 = 12 and FFFE = 34 while bus writes C100 = 56 in the same cycle → all three read back. FFFF is not selected, so hram_bus.rdata = FF.

Source files
------------

// File: rtl/mmu_addresses_pkg.sv
// -----------------------------------------------------------------------------
// mmu_addresses_pkg
// Address map constants shared by the MMU peripherals, plus the state type of
// the RAM clear sequencer and a small range-decode helper.
//
// Contents:
//   SVBK_addr                          WRAM bank select register (FF70)
//   WRAM_bank0_start / WRAM_bank0_end  fixed WRAM bank window   (C000..CFFF)
//   WRAM_bankN_start / WRAM_bankN_end  switchable WRAM window   (D000..DFFF)
//   Echo_start / Echo_end / Echo_offset  echo mirror of C000..DDFF
//   HRAM_start                         first HRAM byte (FF80)
//   clear_state_e                      CLEAR / IDLE states of ram_clear_seq
//   in_range()                         inclusive address window test
// -----------------------------------------------------------------------------
package mmu_addresses_pkg;

  localparam logic [15:0] SVBK_addr        = 16'hFF70;

  localparam logic [15:0] WRAM_bank0_start = 16'hC000;
  localparam logic [15:0] WRAM_bank0_end   = 16'hCFFF;
  localparam logic [15:0] WRAM_bankN_start = 16'hD000;
  localparam logic [15:0] WRAM_bankN_end   = 16'hDFFF;

  localparam logic [15:0] Echo_start       = 16'hE000;
  localparam logic [15:0] Echo_end         = 16'hFDFF;
  localparam logic [15:0] Echo_offset      = 16'h2000;

  localparam logic [15:0] HRAM_start       = 16'hFF80;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clear_state_e;

  function automatic logic in_range(input logic [15:0] addr,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/Bus_if.sv
// -----------------------------------------------------------------------------
// Bus_if
// Simple combinational-read peripheral bus used on the MMU side.
//
// Signals:
//   addr     16-bit byte address
//   wdata    write data
//   rdata    read data returned by the peripheral (FF when not selected)
//   read_en  read strobe
//   write_en write strobe, committed by the peripheral on posedge clk
//
// Modports:
//   Peripheral_side  seen by a memory or register block
//   Master_side      seen by the MMU driving the access
// -----------------------------------------------------------------------------
interface Bus_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        read_en;
  logic        write_en;

  modport Peripheral_side (
    input  addr,
    input  wdata,
    input  read_en,
    input  write_en,
    output rdata
  );

  modport Master_side (
    output addr,
    output wdata,
    output read_en,
    output write_en,
    input  rdata
  );
endinterface

// File: rtl/ram_clear_seq.sv
// -----------------------------------------------------------------------------
// ram_clear_seq
// Post-reset clear sequencer. After reset it walks a counter over every array
// location, one per cycle, requesting a zero write at each. Once the final
// location is written it parks in IDLE until the next reset.
//
// Parameters:
//   DEPTH     number of locations to clear (power of two)
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset; restarts the sequence at 0
//   busy      high while clearing
//   clr_we    zero-write request for clr_addr this cycle
//   clr_addr  location being cleared this cycle
// -----------------------------------------------------------------------------
module ram_clear_seq
  import mmu_addresses_pkg::*;
#(
  parameter  int DEPTH = 32768,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clear_state_e  state;
  clear_state_e  state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        busy    = 1'b1;
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        // The last location is written on the same edge that leaves CLEAR,
        // so busy drops exactly DEPTH cycles after reset releases.
        if (cnt == LAST_ADDR) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        // Terminal until the next reset.
      end
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/banked_ram.sv
// -----------------------------------------------------------------------------
// banked_ram
// CGB-style banked work RAM with echo mirror, separate HRAM and the SVBK bank
// select register.
//
//   C000..CFFF  WRAM bank 0
//   D000..DFFF  WRAM switchable bank (eff_bank)
//   E000..FDFF  echo of C000..DDFF
//   FF80..      HRAM, HRAM_LEN bytes
//   FF70        SVBK (io_bus), only decoded when cgb_mode = 1
//
// Reads are combinational and return FF unless the address is selected,
// read_en is high and no clear is in progress. Writes commit on posedge clk.
//
// Optional feature (macro RAM_CLEAR_ON_RESET_EN): a clear sequencer zeroes
// both arrays after every reset and holds busy high while it runs; WRAM and
// HRAM accesses are ignored while busy. Without the macro busy is tied low and
// array contents after reset are undefined.
//
// Parameters:
//   NUM_BANKS   number of WRAM banks (power of two, >= 2)
//   BANK_SIZE   bytes per WRAM bank (power of two)
//   HRAM_LEN    HRAM bytes
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   bus       WRAM / echo accesses
//   hram_bus  HRAM accesses
//   io_bus    I/O register accesses (only SVBK decoded)
//   cgb_mode  1 = CGB banking, 0 = DMG behaviour (switchable bank fixed at 1)
//   busy      clear sequence in progress
// -----------------------------------------------------------------------------
module banked_ram
  import mmu_addresses_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int BANK_SIZE = 4096,
  parameter int HRAM_LEN  = 127
) (
  input  logic            clk,
  input  logic            reset,
  Bus_if.Peripheral_side  bus,
  Bus_if.Peripheral_side  hram_bus,
  Bus_if.Peripheral_side  io_bus,
  input  logic            cgb_mode,
  output logic            busy
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int OFF_BITS  = $clog2(BANK_SIZE);
  localparam int DEPTH     = NUM_BANKS * BANK_SIZE;
  localparam int WRAM_AW   = BANK_BITS + OFF_BITS;
  localparam int HRAM_AW   = $clog2(HRAM_LEN + 1);

  localparam logic [15:0] HRAM_end = HRAM_start + 16'(HRAM_LEN - 1);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [7:0] wram [DEPTH];
  logic [7:0] hram [HRAM_LEN];

  // ---------------------------------------------------------------------------
  // Clear sequencer hookup
  // ---------------------------------------------------------------------------
  logic               clr_we;
  logic [WRAM_AW-1:0] clr_addr;

`ifdef RAM_CLEAR_ON_RESET_EN
  ram_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  // Normal WRAM/HRAM traffic is only honoured outside reset and outside a
  // clear. SVBK deliberately ignores busy.
  logic access_ok;
  assign access_ok = !reset && !busy;

  // ---------------------------------------------------------------------------
  // SVBK register
  // ---------------------------------------------------------------------------
  logic [BANK_BITS-1:0] svbk;
  logic                 svbk_sel;
  logic [BANK_BITS-1:0] eff_bank;
  logic [7:0]           svbk_rd;

  assign svbk_sel = cgb_mode && (io_bus.addr == SVBK_addr);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the same-cycle SVBK write / D000 access relies on it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      svbk <= '0;
    end else if (io_bus.write_en && svbk_sel) begin
      svbk <= io_bus.wdata[BANK_BITS-1:0];
    end
  end

  // SVBK = 0 still addresses bank 1; the register keeps the written 0.
  assign eff_bank = (!cgb_mode || (svbk == '0)) ? BANK_BITS'(1) : svbk;

  // Unused upper bits of the register read back as ones.
  always_comb begin
    svbk_rd                = 8'hFF;
    svbk_rd[BANK_BITS-1:0] = svbk;
  end

  always_comb begin
    io_bus.rdata = 8'hFF;
    if (!reset && io_bus.read_en && svbk_sel) begin
      io_bus.rdata = svbk_rd;
    end
  end

  // ---------------------------------------------------------------------------
  // WRAM / echo decode
  // ---------------------------------------------------------------------------
  logic                 wram_sel;
  logic [15:0]          wram_addr;
  logic [BANK_BITS-1:0] wram_bank;
  logic [WRAM_AW-1:0]   wram_idx;
  logic                 wram_we;

  always_comb begin
    wram_sel  = in_range(bus.addr, WRAM_bank0_start, Echo_end);
    // Fold the echo window back onto C000..DDFF before bank selection.
    wram_addr = (bus.addr >= Echo_start) ? (bus.addr - Echo_offset) : bus.addr;
    wram_bank = (wram_addr >= WRAM_bankN_start) ? eff_bank : '0;
    wram_idx  = {wram_bank, wram_addr[OFF_BITS-1:0]};
  end

  assign wram_we = bus.write_en && wram_sel && access_ok;

  always_comb begin
    bus.rdata = 8'hFF;
    if (bus.read_en && wram_sel && access_ok) begin
      bus.rdata = wram[wram_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // HRAM decode
  // ---------------------------------------------------------------------------
  logic               hram_sel;
  logic [HRAM_AW-1:0] hram_idx;
  logic               hram_we;
  logic               clr_hram;
  logic [HRAM_AW-1:0] clr_hram_idx;

  assign hram_sel     = in_range(hram_bus.addr, HRAM_start, HRAM_end);
  assign hram_idx     = HRAM_AW'(hram_bus.addr - HRAM_start);
  assign hram_we      = hram_bus.write_en && hram_sel && access_ok;

  // HRAM is much smaller than WRAM, so the clear only touches it while the
  // shared counter is still inside the HRAM range.
  assign clr_hram     = clr_we && (32'(clr_addr) < HRAM_LEN);
  assign clr_hram_idx = HRAM_AW'(clr_addr);

  always_comb begin
    hram_bus.rdata = 8'hFF;
    if (hram_bus.read_en && hram_sel && access_ok) begin
      hram_bus.rdata = hram[hram_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Array write ports
  // ---------------------------------------------------------------------------
  // NOTE: the arrays are not reset; clearing them is the job of the optional
  // sequencer, which keeps these blocks mappable onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      wram[clr_addr] <= 8'h00;
    end else if (wram_we) begin
      wram[wram_idx] <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_hram) begin
      hram[clr_hram_idx] <= 8'h00;
    end else if (hram_we) begin
      hram[hram_idx] <= hram_bus.wdata;
    end
  end

endmodule
